pmem_write_buffer: RTL and testbench
====================================

# pmem_write_buffer

Line-granular eviction write buffer between the `mem_heirarchy` pmem-side port and physical memory. It absorbs 256-bit write-backs in one cycle and drains them to pmem in FIFO order when the upstream side is idle. Read misses are serviced directly from buffered lines when they match, otherwise by a pmem read.

## Interface
- `DEPTH`, default 4: number of line entries; power of two, ≥2.
- `clk`  in  1  clock; all state changes on rising edge.
- `rst_n`  in  1  reset; synchronous, active-low.
- `mem_read`  in  1  upstream line read request; held until `mem_resp`.
- `mem_write`  in  1  upstream line write-back request; held until `mem_resp`.
- `mem_address`  in  32  upstream line address; bits [4:0] ignored.
- `mem_wdata`  in  256  upstream write-back line.
- `mem_resp`  out  1  one-cycle completion pulse to upstream.
- `mem_rdata`  out  256  read line; valid while `mem_resp` is high after a read.
- `pmem_read`  out  1  pmem line read; held until `pmem_resp`.
- `pmem_write`  out  1  pmem line write; held until `pmem_resp`.
- `pmem_address`  out  32  pmem line address; bits [4:0] always 0.
- `pmem_wdata`  out  256  pmem write line.
- `pmem_resp`  in  1  pmem completion pulse.
- `pmem_rdata`  in  256  pmem read line; sampled on `pmem_resp`.

## Operation
- Storage: `DEPTH` entries {valid, tag[31:5], line[255:0]}; circular FIFO, `head`/`tail` wrap mod `DEPTH`, `count` ∈ [0, `DEPTH`]. Full: `count==DEPTH`; empty: `count==0`.
- Match: compare `mem_address[31:5]` against all valid tags; on multiple matches the youngest wins.
- FSM states: IDLE, RESP, FILL, DRAIN.
- IDLE, priority order:
  - `mem_write` and (match or not full): write entry (see Configuration), go RESP.
  - `mem_write`, full, no match: go DRAIN.
  - `mem_read`, match: copy matched line into `mem_rdata`, go RESP.
  - `mem_read`, no match: latch line address, go FILL.
  - No request, `count>0`: go DRAIN.
  - If `mem_read` and `mem_write` are both high, the write is taken. This is an illegal input.
- FILL: `pmem_read`=1, `pmem_address`=latched address. On `pmem_resp`, `mem_rdata`←`pmem_rdata`, go RESP.
- DRAIN: `pmem_write`=1, `pmem_address`/`pmem_wdata` from the head entry. On `pmem_resp`, invalidate head, `head`++, `count`--, go IDLE.
- RESP: `mem_resp`=1 for exactly one cycle, then IDLE. Requests are ignored in RESP, because the upstream request is still asserted that cycle.
- A pmem transaction is never aborted. An upstream request arriving during DRAIN waits for that drain to finish.
- Read of a buffered line never touches pmem. Ordering is safe: reads bypass only non-matching entries.

## Timing
- Reset (`rst_n`=0 at an edge): state IDLE, `count`/`head`/`tail`=0, all valid=0; `mem_resp`, `pmem_read`, `pmem_write`=0; `mem_rdata`, `pmem_address`, `pmem_wdata`=0.
- Reset mid-transaction: buffered lines are discarded, and pmem strobes drop the next cycle.
- All outputs are registered or Moore-decoded from state. There are no combinational in→out paths.
- Write accept (not full, or match): request seen in IDLE at cycle N → `mem_resp` at N+1.
- Read hit: request at N → `mem_resp` with data at N+1.
- Read miss: `pmem_read` from N+1 until `pmem_resp` at cycle M → `mem_resp` at M+1.
- Write when full, no match: one drain (pmem latency) + 1 cycle IDLE + 1 cycle RESP.
- Upstream may present a new request at the cycle after `mem_resp`.

## Configuration
- `WBUF_COALESCE_EN` defined: a write that matches a valid entry overwrites that entry's line in place. There is no allocation and `count` is unchanged, so at most one entry per tag exists.
- `WBUF_COALESCE_EN` undefined: every write allocates at `tail` (`tail`++, `count`++). Duplicate tags may coexist and drain in arrival order. A write that matches while full stalls for a drain like a non-matching one. Read match returns the youngest.

## Test plan
- Write 0x0000_1000 line A (all 0xAA), then read 0x0000_1010 → `mem_resp` 1 cycle after read request, `mem_rdata`=A, no `pmem_read` asserted.
- With `DEPTH`=4, issue 4 back-to-back writes to 0x100, 0x200, 0x300, 0x400, holding pmem unresponsive. Then write 0x500 → no `mem_resp` until one `pmem_write` to 0x100 completes; `mem_resp` arrives 2 cycles after that `pmem_resp`.
- Read miss 0x8000 with 0x100 buffered → `pmem_read` with `pmem_address`=0x8000 is issued before any drain. On `pmem_resp` with line B, `mem_resp` follows 1 cycle later with `mem_rdata`=B.
- Idle drain: buffer writes 0x100 (C) and 0x200 (D), then stay idle → `pmem_write` 0x100/C, then 0x200/D, each held until `pmem_resp`; `count` reaches 0.
- Coalesce: write 0x300 E, then 0x300 F, then drain.
  - With `WBUF_COALESCE_EN`: one `pmem_write` of F.
  - Without it: `pmem_write` E then F; an intermediate read of 0x300 returns F.
- Assert `rst_n`=0 during DRAIN → next cycle `pmem_write`=0, `count`=0; a later read of the drained address goes to pmem.

Source files
------------

// File: rtl/pmem_write_buffer.sv
// Line-granular eviction write buffer between the cache hierarchy and pmem.
// Optional build macro WBUF_COALESCE_EN: a write hitting a buffered line overwrites it in place.
module pmem_write_buffer #(
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         mem_read,
  input  logic         mem_write,
  input  logic [31:0]  mem_address,
  input  logic [255:0] mem_wdata,
  output logic         mem_resp,
  output logic [255:0] mem_rdata,
  output logic         pmem_read,
  output logic         pmem_write,
  output logic [31:0]  pmem_address,
  output logic [255:0] pmem_wdata,
  input  logic         pmem_resp,
  input  logic [255:0] pmem_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RESP, S_FILL, S_DRAIN} state_e;

  state_e                  state_q, state_d;
  logic [DEPTH-1:0]        vld_q, vld_d;
  logic [DEPTH-1:0][26:0]  tag_q;
  logic [DEPTH-1:0][255:0] line_q;
  logic [AW-1:0]           head_q, head_d, tail_q, tail_d;
  logic [AW:0]             cnt_q, cnt_d;
  logic [255:0]            rdata_q, rdata_d, pwdata_q, pwdata_d;
  logic [31:0]             paddr_q, paddr_d;

  logic [DEPTH-1:0]        match;
  logic                    hit, full, wr_ok, ent_we;
  logic [AW-1:0]           hit_idx, ent_idx, idx;
  logic                    unused_addr_lsb;

  assign unused_addr_lsb = ^mem_address[4:0];
  assign full = (cnt_q == DEPTH_C);

  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    assign match[g] = vld_q[g] && (tag_q[g] == mem_address[31:5]);
  end

  // Walk oldest to youngest from head so the last match seen is the youngest.
  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    idx     = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head_q + AW'(k);
      if (match[idx]) begin
        hit     = 1'b1;
        hit_idx = idx;
      end
    end
  end

`ifdef WBUF_COALESCE_EN
  assign wr_ok = hit || !full;
`else
  assign wr_ok = !full;
`endif

  always_comb begin
    state_d  = state_q;
    vld_d    = vld_q;
    head_d   = head_q;
    tail_d   = tail_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    paddr_d  = paddr_q;
    pwdata_d = pwdata_q;
    ent_we   = 1'b0;
    ent_idx  = tail_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_write) begin
          if (wr_ok) begin
            ent_we  = 1'b1;
            state_d = S_RESP;
`ifdef WBUF_COALESCE_EN
            if (hit) begin
              ent_idx = hit_idx;
            end else begin
              vld_d[tail_q] = 1'b1;
              tail_d        = tail_q + 1'b1;
              cnt_d         = cnt_q + 1'b1;
            end
`else
            vld_d[tail_q] = 1'b1;
            tail_d        = tail_q + 1'b1;
            cnt_d         = cnt_q + 1'b1;
`endif
          end else begin
            paddr_d  = {tag_q[head_q], 5'b0};
            pwdata_d = line_q[head_q];
            state_d  = S_DRAIN;
          end
        end else if (mem_read) begin
          if (hit) begin
            rdata_d = line_q[hit_idx];
            state_d = S_RESP;
          end else begin
            paddr_d = {mem_address[31:5], 5'b0};
            state_d = S_FILL;
          end
        end else if (cnt_q != '0) begin
          paddr_d  = {tag_q[head_q], 5'b0};
          pwdata_d = line_q[head_q];
          state_d  = S_DRAIN;
        end
      end
      S_FILL: begin
        if (pmem_resp) begin
          rdata_d = pmem_rdata;
          state_d = S_RESP;
        end
      end
      S_DRAIN: begin
        if (pmem_resp) begin
          vld_d[head_q] = 1'b0;
          head_d        = head_q + 1'b1;
          cnt_d         = cnt_q - 1'b1;
          state_d       = S_IDLE;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      vld_q    <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      paddr_q  <= '0;
      pwdata_q <= '0;
    end else begin
      state_q  <= state_d;
      vld_q    <= vld_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      paddr_q  <= paddr_d;
      pwdata_q <= pwdata_d;
    end
  end

  // Payload needs no reset: valid bits gate every use.
  always_ff @(posedge clk) begin
    if (ent_we) begin
      tag_q[ent_idx]  <= mem_address[31:5];
      line_q[ent_idx] <= mem_wdata;
    end
  end

  assign mem_resp     = (state_q == S_RESP);
  assign pmem_read    = (state_q == S_FILL);
  assign pmem_write   = (state_q == S_DRAIN);
  assign mem_rdata    = rdata_q;
  assign pmem_address = paddr_q;
  assign pmem_wdata   = pwdata_q;
endmodule

// File: tb/tb_pmem_write_buffer.sv
// Scoreboard bench for pmem_write_buffer with a latency-controlled pmem model.
module tb_pmem_write_buffer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         mem_read, mem_write, mem_resp;
  logic [31:0]  mem_address;
  logic [255:0] mem_wdata, mem_rdata;
  logic         pmem_read, pmem_write, pmem_resp;
  logic [31:0]  pmem_address;
  logic [255:0] pmem_wdata, pmem_rdata;

  pmem_write_buffer #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_resp(mem_resp), .mem_rdata(mem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_fail = 0;
  logic [255:0] exp_rd_q[$];
  logic [31:0]  exp_pr_q[$];
  logic [31:0]  exp_pa_q[$];
  logic [255:0] exp_pd_q[$];
  logic [255:0] pmem_mem [logic [31:0]];
  bit pmem_en = 1'b1;
  int pmem_lat = 2, wait_cnt = 0;
  int pw_done = 0, pr_done = 0, pw_cyc = 0, pr_cyc = 0, pr_seen = 0;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [255:0] pat(input logic [31:0] a);
    return {8{a}};
  endfunction

  // pmem model: responds after pmem_lat cycles of a held strobe, scoreboards every transfer.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(posedge clk); #1;
      pmem_resp = 1'b0;
      if (pmem_read) pr_seen++;
      if (pmem_en && (pmem_read || pmem_write)) begin
        if (wait_cnt >= pmem_lat) begin
          wait_cnt  = 0;
          pmem_resp = 1'b1;
          if (pmem_write) begin
            chk("pw_expected", exp_pa_q.size() != 0, 1);
            if (exp_pa_q.size() != 0) begin
              chk("pw_addr", pmem_address, exp_pa_q.pop_front());
              chk("pw_data", pmem_wdata, exp_pd_q.pop_front());
            end
            pmem_mem[pmem_address] = pmem_wdata;
            pw_done++;
            pw_cyc = cyc;
          end else begin
            chk("pr_expected", exp_pr_q.size() != 0, 1);
            if (exp_pr_q.size() != 0) chk("pr_addr", pmem_address, exp_pr_q.pop_front());
            pmem_rdata = pmem_mem.exists(pmem_address) ? pmem_mem[pmem_address] : pat(pmem_address);
            pr_done++;
            pr_cyc = cyc;
          end
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  task automatic exp_pw(input logic [31:0] a, input logic [255:0] d);
    exp_pa_q.push_back({a[31:5], 5'b0});
    exp_pd_q.push_back(d);
  endtask

  task automatic wr(input logic [31:0] a, input logic [255:0] d, output int lat, output int rcyc);
    mem_address = a; mem_wdata = d; mem_write = 1'b1; lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1; lat++;
      if (mem_resp) break;
    end
    chk("wr_resp", mem_resp, 1);
    rcyc = cyc;
    mem_write = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic rd(input logic [31:0] a, input logic [255:0] d, input bit miss,
                    output int lat, output int rcyc);
    exp_rd_q.push_back(d);
    if (miss) exp_pr_q.push_back({a[31:5], 5'b0});
    mem_address = a; mem_read = 1'b1; lat = 0;
    while (lat < 300) begin
      @(posedge clk); #1; lat++;
      if (mem_resp) break;
    end
    chk("rd_resp", mem_resp, 1);
    if (mem_resp) chk("rdata", mem_rdata, exp_rd_q.pop_front());
    rcyc = cyc;
    mem_read = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_pa_q.size() != 0 && n < 300) begin
      @(posedge clk); #1; n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_left", exp_pa_q.size(), 0);
    chk("drain_idle", pmem_write, 0);
  endtask

  initial begin
    int lat, rc, snap, snap2;
    logic [255:0] ln_a, ln_b, ln_c, ln_d, ln_e, ln_f, ln_g;
    ln_a = {32{8'hAA}}; ln_b = {32{8'hBB}}; ln_c = {32{8'hCC}};
    ln_d = {32{8'hDD}}; ln_e = {32{8'hEE}}; ln_f = {32{8'hF1}};
    ln_g = {32{8'h66}};
    pmem_mem[32'h8000] = ln_b;
    rst_n = 1'b0; mem_read = 1'b0; mem_write = 1'b0; mem_address = '0; mem_wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_resp", mem_resp, 0);
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_mem_rdata", mem_rdata, 0);
    chk("rst_pmem_addr", pmem_address, 0);
    chk("rst_pmem_wdata", pmem_wdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // write then read hit within the same line
    snap = pr_seen;
    exp_pw(32'h1000, ln_a);
    wr(32'h1000, ln_a, lat, rc);
    chk("hit_wr_lat", lat, 1);
    rd(32'h1010, ln_a, 1'b0, lat, rc);
    chk("hit_rd_lat", lat, 1);
    chk("hit_no_pread", pr_seen, snap);
    wait_drain();

    // fill buffer, then a write must wait for one drain
    pmem_en = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      exp_pw(32'h100 * i, pat(32'h100 * i));
      wr(32'h100 * i, pat(32'h100 * i), lat, rc);
      chk("fill_wr_lat", lat, 1);
    end
    exp_pw(32'h500, pat(32'h500));
    snap = pw_done;
    fork
      wr(32'h500, pat(32'h500), lat, rc);
      begin
        repeat (6) @(posedge clk);
        #2;
        chk("full_stalled", pw_done, snap);
        pmem_en = 1'b1;
      end
    join
    chk("full_one_drain", pw_done, snap + 1);
    chk("full_resp_gap", rc - pw_cyc, 2);
    wait_drain();

    // read miss goes to pmem ahead of the buffered drain
    exp_pw(32'h100, ln_c);
    wr(32'h100, ln_c, lat, rc);
    snap = pw_done;
    rd(32'h8000, ln_b, 1'b1, lat, rc);
    chk("miss_no_drain_first", pw_done, snap);
    chk("miss_resp_gap", rc - pr_cyc, 1);
    wait_drain();

    // idle drain of two lines in order
    snap = pw_done;
    exp_pw(32'h100, ln_c);
    wr(32'h100, ln_c, lat, rc);
    exp_pw(32'h200, ln_d);
    wr(32'h200, ln_d, lat, rc);
    wait_drain();
    chk("idle_drain_cnt", pw_done - snap, 2);
    chk("idle_count_zero", dut.cnt_q, 0);

    // same-line rewrite
    pmem_en = 1'b0;
    snap = pw_done;
    snap2 = pr_seen;
`ifdef WBUF_COALESCE_EN
    exp_pw(32'h300, ln_f);
`else
    exp_pw(32'h300, ln_e);
    exp_pw(32'h300, ln_f);
`endif
    wr(32'h300, ln_e, lat, rc);
    wr(32'h300, ln_f, lat, rc);
    rd(32'h300, ln_f, 1'b0, lat, rc);
    chk("coal_rd_lat", lat, 1);
    chk("coal_no_pread", pr_seen, snap2);
    pmem_en = 1'b1;
    wait_drain();
`ifdef WBUF_COALESCE_EN
    chk("coal_drains", pw_done - snap, 1);
`else
    chk("coal_drains", pw_done - snap, 2);
`endif

    // reset during drain discards the line
    pmem_en = 1'b0;
    exp_pw(32'h600, ln_g);
    wr(32'h600, ln_g, lat, rc);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_drain_active", pmem_write, 1);
    chk("rst_drain_addr", pmem_address, 32'h600);
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid_pwrite", pmem_write, 0);
    chk("rst_mid_count", dut.cnt_q, 0);
    rst_n = 1'b1;
    exp_pa_q.delete();
    exp_pd_q.delete();
    pmem_en = 1'b1;
    snap = pr_done;
    rd(32'h600, pat(32'h600), 1'b1, lat, rc);
    chk("rst_rd_from_pmem", pr_done - snap, 1);
    repeat (8) @(posedge clk);
    #1;
    chk("end_idle", pmem_write, 0);
    chk("end_rd_left", exp_rd_q.size(), 0);
    chk("end_pr_left", exp_pr_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
